// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {RUN, DROP, HALT} fetch_state_e;

    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_INSTR_W = 16;

    typedef struct packed {
        logic [DEF_INSTR_W-1:0] instr;
        logic [DEF_ADDR_W-1:0]  pc;
    } fetch_entry_t;

    // Occupancy counters must be able to hold the value DEPTH itself.
    function automatic int cntWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch front-end bundle: redirect/halt control, memory handshake and decode port.
interface fetch_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 4
);
    localparam int CNT_W = cntWidth(DEPTH);

    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               halt_req;
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_ack;
    logic [INSTR_W-1:0] mem_rdata;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic [ADDR_W-1:0]  out_pc_next;
    logic [CNT_W-1:0]   level;
    logic               idle;

    modport master (
        input  redirect, redirect_pc, halt_req, mem_ack, mem_rdata, out_ready,
        output mem_req, mem_addr, out_valid, out_instr, out_pc, out_pc_next, level, idle
    );

    modport slave (
        output redirect, redirect_pc, halt_req, mem_ack, mem_rdata, out_ready,
        input  mem_req, mem_addr, out_valid, out_instr, out_pc, out_pc_next, level, idle
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous first-word-fall-through FIFO with clear; DEPTH must be a power of 2.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int CNT_W = cntWidth(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q, rdPtr_q;
    logic [CNT_W-1:0] level_q;
    logic             doPush, doPop;

    assign doPush = push_i && (level_q != FULL);
    assign doPop  = pop_i && (level_q != '0);

    // Pointers are exactly log2(DEPTH) bits wide, so incrementing wraps them.
    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
            if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
            level_q <= level_q + CNT_W'(doPush) - CNT_W'(doPop);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush && !clear_i) mem_q[wrPtr_q] <= data_i;
    end

    assign data_o  = mem_q[rdPtr_q];
    assign level_o = level_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC sequencing, memory req/ack, prefetch queue, redirect and halt.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 16,
    parameter int                DEPTH    = 4,
    parameter int                PC_STEP  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic     clk,
    input  logic     rst_n,
    fetch_if.master  bus
);
    localparam int CNT_W   = cntWidth(DEPTH);
    localparam int ENTRY_W = INSTR_W + ADDR_W;
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);
    localparam logic [CNT_W-1:0]  FULL = CNT_W'(DEPTH);

    fetch_state_e      state_q, state_d;
    logic              memReq_q, memReq_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic              haltPend_q, haltPend_d;
    logic              idle_q, idle_d;

    logic [CNT_W-1:0]   level;
    logic [ENTRY_W-1:0] head;
    logic               outValid, popReq, ackSeen, roomAfterAck;
    logic               push, fifoPop, clear;

    assign outValid     = (level != '0);
    assign popReq       = outValid && bus.out_ready;
    assign ackSeen      = memReq_q && bus.mem_ack;
    // A request is only issued with room, so an ack never arrives with the queue full.
    assign roomAfterAck = popReq || (level < FULL - CNT_W'(1));

    always_comb begin
        state_d    = state_q;
        memReq_d   = memReq_q;
        memAddr_d  = memAddr_q;
        target_d   = target_q;
        haltPend_d = haltPend_q;
        push       = 1'b0;
        fifoPop    = popReq;
        clear      = 1'b0;
        if (bus.redirect) begin
            clear      = 1'b1;
            fifoPop    = 1'b0;
            haltPend_d = 1'b0;
            if (!memReq_q || bus.mem_ack) begin
                memAddr_d = bus.redirect_pc;
                memReq_d  = 1'b1;
                state_d   = RUN;
            end else begin
                target_d = bus.redirect_pc;
                state_d  = DROP;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (ackSeen) begin
                        push      = 1'b1;
                        memAddr_d = memAddr_q + STEP;
                        memReq_d  = roomAfterAck && !bus.halt_req;
                        if (bus.halt_req) state_d = HALT;
                    end else if (bus.halt_req) begin
                        state_d = HALT;
                    end else if (!memReq_q && level < FULL) begin
                        memReq_d = 1'b1;
                    end
                end
                DROP: begin
                    if (ackSeen) begin
                        memAddr_d  = target_q;
                        memReq_d   = !(haltPend_q || bus.halt_req);
                        state_d    = (haltPend_q || bus.halt_req) ? HALT : RUN;
                        haltPend_d = 1'b0;
                    end else if (bus.halt_req) begin
                        haltPend_d = 1'b1;
                    end
                end
                HALT: begin
                    if (ackSeen) begin
                        push      = 1'b1;
                        memAddr_d = memAddr_q + STEP;
                        memReq_d  = 1'b0;
                    end
                end
                default: state_d = RUN;
            endcase
        end
        idle_d = (state_d == HALT) && !memReq_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            memReq_q   <= 1'b0;
            memAddr_q  <= RESET_PC;
            target_q   <= '0;
            haltPend_q <= 1'b0;
            idle_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            memReq_q   <= memReq_d;
            memAddr_q  <= memAddr_d;
            target_q   <= target_d;
            haltPend_q <= haltPend_d;
            idle_q     <= idle_d;
        end
    end

    fetch_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (clear),
        .push_i  (push),
        .data_i  ({bus.mem_rdata, memAddr_q}),
        .pop_i   (fifoPop),
        .data_o  (head),
        .level_o (level)
    );

    assign bus.mem_req     = memReq_q;
    assign bus.mem_addr    = memAddr_q;
    assign bus.level       = level;
    assign bus.idle        = idle_q;
    assign bus.out_valid   = outValid;
    assign bus.out_instr   = outValid ? head[ENTRY_W-1:ADDR_W] : '0;
    assign bus.out_pc      = outValid ? head[ADDR_W-1:0] : '0;
    assign bus.out_pc_next = outValid ? head[ADDR_W-1:0] + STEP : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed scoreboard bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_if #(.ADDR_W(16), .INSTR_W(16), .DEPTH(4)) bus ();
    fetch_if #(.ADDR_W(16), .INSTR_W(16), .DEPTH(4)) bus2 ();

    fetch_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    fetch_unit #(.RESET_PC(16'hFFFC)) dutWrap (.clk(clk), .rst_n(rst_n), .bus(bus2));

    // The wrap instance sees an always-ready decoder and a zero-latency memory.
    assign bus2.redirect    = 1'b0;
    assign bus2.redirect_pc = 16'h0000;
    assign bus2.halt_req    = 1'b0;
    assign bus2.out_ready   = 1'b1;
    assign bus2.mem_ack     = bus2.mem_req;
    assign bus2.mem_rdata   = bus2.mem_addr ^ 16'hA5A5;

    int checks = 0;
    int errors = 0;

    fetch_entry_t mq[$];
    fetch_entry_t expQ[$];
    logic [15:0]  mAddr, mTarget, lastPopPc;
    bit           mReq, mHalted, mDropping, mHaltPend;
    int           memLat, memWait;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        expQ.delete();
        mAddr = 16'h0000; mTarget = 16'h0000;
        mReq = 0; mHalted = 0; mDropping = 0; mHaltPend = 0;
        memWait = 0;
    endtask

    // One clock edge of the fetch front end expressed as queue operations.
    task automatic modelStep(input bit rd, input logic [15:0] rpc, input bit hl, input bit ack, input bit rdy);
        int lvl0;
        bit ackEff;
        fetch_entry_t e;
        lvl0   = mq.size();
        ackEff = ack && mReq;
        if (rd) begin
            mq.delete();
            mHalted = 0; mHaltPend = 0;
            if (!mReq || ackEff) begin
                mAddr = rpc; mReq = 1; mDropping = 0;
            end else begin
                mTarget = rpc; mDropping = 1;
            end
        end else begin
            if (lvl0 != 0 && rdy) expQ.push_back(mq.pop_front());
            if (mDropping) begin
                if (ackEff) begin
                    mAddr = mTarget;
                    mDropping = 0;
                    if (mHaltPend || hl) begin mHalted = 1; mReq = 0; end
                    else mReq = 1;
                    mHaltPend = 0;
                end else if (hl) begin
                    mHaltPend = 1;
                end
            end else begin
                if (hl) mHalted = 1;
                if (ackEff) begin
                    e.instr = mAddr ^ 16'hA5A5;
                    e.pc    = mAddr;
                    mq.push_back(e);
                    mAddr = mAddr + 16'd2;
                    mReq  = !mHalted && (mq.size() < 4);
                end else if (!mHalted && !mReq && lvl0 < 4) begin
                    mReq = 1;
                end
            end
        end
    endtask

    task automatic checkOutput();
        check("mem_req",   32'(bus.mem_req),   32'(mReq));
        check("mem_addr",  32'(bus.mem_addr),  32'(mAddr));
        check("level",     32'(bus.level),     32'(mq.size()));
        check("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
        check("idle",      32'(bus.idle),      32'(mHalted && !mReq));
    endtask

    // Drive one cycle of inputs (memory acks after memLat waiting cycles), advance model, check.
    task automatic applyStimulus(input bit rd, input logic [15:0] rpc, input bit hl, input bit rdy);
        bit reqNow, ack;
        reqNow = (bus.mem_req === 1'b1);
        ack    = reqNow && (memWait >= memLat);
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.halt_req    = hl;
        bus.out_ready   = rdy;
        bus.mem_ack     = ack;
        bus.mem_rdata   = bus.mem_addr ^ 16'hA5A5;
        modelStep(rd, rpc, hl, ack, rdy);
        @(posedge clk);
        #1;
        if (ack) memWait = 0;
        else if (reqNow) memWait++;
        checkOutput();
    endtask

    task automatic doReset();
        bus.redirect = 0; bus.redirect_pc = 0; bus.halt_req = 0;
        bus.out_ready = 0; bus.mem_ack = 0; bus.mem_rdata = 0;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        modelReset();
        check("rst_mem_req",     32'(bus.mem_req),     32'd0);
        check("rst_mem_addr",    32'(bus.mem_addr),    32'd0);
        check("rst_level",       32'(bus.level),       32'd0);
        check("rst_out_valid",   32'(bus.out_valid),   32'd0);
        check("rst_idle",        32'(bus.idle),        32'd0);
        check("rst_out_instr",   32'(bus.out_instr),   32'd0);
        check("rst_out_pc",      32'(bus.out_pc),      32'd0);
        check("rst_out_pc_next", 32'(bus.out_pc_next), 32'd0);
        rst_n = 1'b1;
    endtask

    // Monitor: every accepted head is compared with the next expected entry.
    initial begin
        fetch_entry_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1 && bus.redirect !== 1'b1) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_pop actual_pc=%h expected=none at %0t", bus.out_pc, $time);
                end else begin
                    e = expQ.pop_front();
                    check("out_pc",      32'(bus.out_pc),      32'(e.pc));
                    check("out_instr",   32'(bus.out_instr),   32'(e.instr));
                    check("out_pc_next", 32'(bus.out_pc_next), 32'(16'(e.pc + 16'd2)));
                    lastPopPc = bus.out_pc;
                end
            end
        end
    end

    initial begin
        int k;
        rst_n  = 1'b0;
        memLat = 0;

        // Streaming at one instruction per cycle; the wrap instance runs alongside.
        doReset();
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(0, 16'h0, 0, 1);
            check("t1_addr", 32'(bus.mem_addr), 32'(16'(2 * (i - 1))));
            if (i >= 2) check("t1_level", 32'(bus.level), 32'd1);
            if (i <= 4) begin
                check("wrap_addr", 32'(bus2.mem_addr), 32'(16'(16'hFFFC + 16'(2 * (i - 1)))));
                if (i >= 2) begin
                    check("wrap_pc",      32'(bus2.out_pc),      32'(16'(16'hFFFC + 16'(2 * (i - 2)))));
                    check("wrap_pc_next", 32'(bus2.out_pc_next), 32'(16'(16'hFFFC + 16'(2 * (i - 1)))));
                end
            end
        end

        // Backpressure fills the queue, one pop reopens fetching.
        doReset();
        for (int i = 0; i < 6; i++) applyStimulus(0, 16'h0, 0, 0);
        check("t2_full_level", 32'(bus.level),    32'd4);
        check("t2_full_req",   32'(bus.mem_req),  32'd0);
        check("t2_full_addr",  32'(bus.mem_addr), 32'h8);
        applyStimulus(0, 16'h0, 0, 1);
        check("t2_pop_level",  32'(bus.level),    32'd3);
        applyStimulus(0, 16'h0, 0, 0);
        check("t2_reissue_req",  32'(bus.mem_req),  32'd1);
        check("t2_reissue_addr", 32'(bus.mem_addr), 32'h8);
        for (int i = 0; i < 10; i++) applyStimulus(0, 16'h0, 0, 1);

        // Redirect while a slow request is in flight: its data must be dropped.
        doReset();
        memLat = 3;
        k = 0;
        while (!(bus.mem_req === 1'b1 && bus.mem_addr === 16'h2) && k < 20) begin
            applyStimulus(0, 16'h0, 0, 1);
            k++;
        end
        check("t3_reach_addr2", 32'(k < 20), 32'd1);
        applyStimulus(0, 16'h0, 0, 1);
        applyStimulus(1, 16'h0040, 0, 1);
        check("t3_hold_addr", 32'(bus.mem_addr), 32'h2);
        check("t3_hold_req",  32'(bus.mem_req),  32'd1);
        k = 0;
        while (bus.out_valid !== 1'b1 && k < 20) begin
            applyStimulus(0, 16'h0, 0, 0);
            k++;
        end
        check("t3_first_pc", 32'(bus.out_pc), 32'h0040);
        for (int i = 0; i < 8; i++) applyStimulus(0, 16'h0, 0, 1);

        // Redirect coinciding with an ack and a pop.
        doReset();
        memLat = 0;
        for (int i = 0; i < 3; i++) applyStimulus(0, 16'h0, 0, 0);
        check("t4_pre_level", 32'(bus.level), 32'd2);
        applyStimulus(1, 16'h0100, 0, 1);
        check("t4_level", 32'(bus.level),    32'd0);
        check("t4_req",   32'(bus.mem_req),  32'd1);
        check("t4_addr",  32'(bus.mem_addr), 32'h0100);
        applyStimulus(0, 16'h0, 0, 0);
        check("t4_first_pc", 32'(bus.out_pc), 32'h0100);
        for (int i = 0; i < 6; i++) applyStimulus(0, 16'h0, 0, 1);

        // Halt with a pending request, drain to idle, then restart via redirect.
        doReset();
        memLat = 2;
        k = 0;
        while (!(bus.mem_req === 1'b1 && bus.mem_addr === 16'h8) && k < 40) begin
            applyStimulus(0, 16'h0, 0, 1);
            k++;
        end
        check("t5_reach_addr8", 32'(k < 40), 32'd1);
        applyStimulus(0, 16'h0, 1, 1);
        k = 0;
        while (!(bus.idle === 1'b1 && bus.out_valid === 1'b0) && k < 20) begin
            applyStimulus(0, 16'h0, 0, 1);
            k++;
        end
        check("t5_idle",     32'(bus.idle),     32'd1);
        check("t5_drained",  32'(bus.level),    32'd0);
        check("t5_no_req",   32'(bus.mem_req),  32'd0);
        check("t5_last_pc",  32'(lastPopPc),    32'h8);
        check("t5_halt_addr", 32'(bus.mem_addr), 32'hA);
        applyStimulus(1, 16'h0020, 0, 1);
        check("t5_wake_idle", 32'(bus.idle),     32'd0);
        check("t5_wake_req",  32'(bus.mem_req),  32'd1);
        check("t5_wake_addr", 32'(bus.mem_addr), 32'h0020);

        // Randomized traffic.
        doReset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) memLat = $urandom_range(0, 3);
            applyStimulus($urandom_range(0, 31) == 0,
                          16'($urandom) & 16'hFFFE,
                          $urandom_range(0, 39) == 0,
                          $urandom_range(0, 3) != 0);
        end

        check("scoreboard_empty", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
